// File: rtl/stdp_weight_readout.sv
// stdp_weight_readout: freezes the STDP engine and streams a snapshot of the weight RAM over valid/ready
module stdp_weight_readout #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WORDS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  engine_idle,
  output logic                  freeze,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, FILL, DRAIN, DONE_S} state_t;
  state_t state, state_nxt;
  logic rd_pending;
  logic [ADDR_WIDTH-1:0] pend_idx;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic hs, last_addr;
  assign hs        = m_valid & m_ready;
  assign last_addr = ram_rd_addr == ADDR_WIDTH'(NUM_WORDS - 1);
  assign ram_rd_en = (state == FILL) && ((int'(count) + int'(rd_pending)) < FIFO_DEPTH);
  assign freeze    = state != IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE_S;
  assign m_valid   = count != '0;
  assign {m_data, m_index} = mem[rd_ptr];
  assign m_last    = m_valid && (m_index == ADDR_WIDTH'(NUM_WORDS - 1));
  // snapshot sequencing: wait for the engine, fill, drain to the last beat, pulse done
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      state_nxt = start ? WAIT_IDLE : IDLE;
      WAIT_IDLE: state_nxt = engine_idle ? FILL : WAIT_IDLE;
      FILL:      state_nxt = (ram_rd_en && last_addr) ? DRAIN : FILL;
      DRAIN:     state_nxt = (hs && m_last) ? DONE_S : DRAIN;
      DONE_S:    state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  // read address: restarts from 0 for every snapshot and parks on the last word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ram_rd_addr <= '0;
    else if (state == IDLE) ram_rd_addr <= '0;
    else if (ram_rd_en && !last_addr) ram_rd_addr <= ram_rd_addr + 1'b1;
  end
  // skid FIFO: captures read data one cycle after each strobe, pops on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pending <= 1'b0;
      pend_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_pending <= ram_rd_en;
      pend_idx   <= ram_rd_addr;
      if (rd_pending) begin
        mem[wr_ptr] <= {ram_rd_data, pend_idx};
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (hs) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(rd_pending) - CW'(hs);
    end
  end
endmodule

// File: tb/tb_stdp_weight_readout.sv
// tb_stdp_weight_readout: scoreboard bench for the weight snapshot streamer
module tb_stdp_weight_readout;
  localparam int DW = 18;
  localparam int AW = 4;
  localparam int N  = 16;
  typedef logic [DW+AW:0] beat_t;
  logic clk = 0, rst = 0, start = 0, engine_idle = 0, m_ready = 0;
  logic freeze, busy, done, ram_rd_en, m_valid, m_last;
  logic [AW-1:0] ram_rd_addr, m_index;
  logic [DW-1:0] ram_rd_data = '0, m_data;
  logic [DW-1:0] ram [N];
  beat_t exp_q[$];
  beat_t e;
  int checks = 0, errors = 0, beats = 0, dones = 0, ready_mode = 0, cyc = 0;
  bit last_hs = 0, prev_stall = 0, prev_flow = 0;
  logic [DW-1:0] pd;
  logic [AW-1:0] pi;
  logic pl;

  stdp_weight_readout dut (
    .clk(clk), .rst(rst), .start(start), .engine_idle(engine_idle),
    .freeze(freeze), .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      last_hs = 0;
      prev_stall = 0;
      prev_flow = 0;
    end else begin
      chk("done_pulse", done, last_hs);
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_index", m_index, pi);
        chk("hold_last", m_last, pl);
      end
      if (prev_flow && ready_mode == 0) chk("no_gap", m_valid, 1);
      last_hs = 0;
      prev_flow = 0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: index %0d data %0h with empty scoreboard", m_index, m_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e[DW+AW:AW+1]);
          chk("index", m_index, e[AW:1]);
          chk("last", m_last, e[0]);
        end
        beats++;
        last_hs = m_last;
        prev_flow = !m_last;
      end
      if (done) dones++;
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pi = m_index;
      pl = m_last;
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_rd_en"}, ram_rd_en, 0);
    chk({tag, "_freeze"}, freeze, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_index"}, m_index, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_addr"}, ram_rd_addr, 0);
  endtask

  task automatic snap(input int idle_delay, input int restart_beat, input int rst_beat);
    int lat, d0;
    bit pulsed;
    pulsed = 0;
    for (int i = 0; i < N; i++) exp_q.push_back({ram[i], AW'(i), i == N - 1});
    beats = 0;
    d0 = dones;
    @(posedge clk);
    #1;
    start = 1;
    engine_idle = (idle_delay == 0);
    @(posedge clk);
    #1;
    start = 0;
    lat = 1;
    chk("freeze_on", freeze, 1);
    for (int k = 0; k < idle_delay; k++) begin
      chk("no_read_while_busy_engine", ram_rd_en, 0);
      chk("frozen", freeze, 1);
      @(posedge clk);
      #1;
    end
    if (idle_delay > 0) begin
      engine_idle = 1;
      lat = 0;
    end
    while (!m_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, idle_delay > 0 ? 3 : 4);
    for (int c = 0; c < 400 && dones == d0; c++) begin
      if (!pulsed && restart_beat >= 0 && beats >= restart_beat) begin
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        pulsed = 1;
      end
      if (rst_beat >= 0 && beats >= rst_beat) begin
        rst = 0;
        #1;
        check_quiet("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        check_quiet("held_reset");
        rst = 1;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("done_count", dones - d0, 1);
    chk("all_beats", beats, N);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("busy_after_done", busy, 0);
    chk("freeze_after_done", freeze, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("single_done", dones - d0, 1);
    chk("idle_stays", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1;
    engine_idle = 1;
    for (int i = 0; i < N; i++) ram[i] = DW'(i - 8);
    ready_mode = 0;
    snap(0, -1, -1);
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
    snap(10, -1, -1);
    ready_mode = 1;
    snap(0, -1, -1);
    ready_mode = 0;
    snap(0, 5, -1);
    snap(0, -1, 7);
    snap(0, -1, -1);
    ram[0] = 18'h1FFFF;
    ram[1] = 18'h20000;
    ready_mode = 2;
    snap(0, -1, -1);
    repeat (3) begin
      for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
      snap(int'($urandom_range(0, 3)), -1, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
